// File: rtl/spad_read_controller_filter.sv
// Filter scratchpad read controller: sweeps spad addresses once per reuse pass, then releases the spad.
// Optional build macro SPAD_RD_STALL_CNT_EN adds the stall_cycles_o counter of stalled READ cycles.
module spad_read_controller_filter #(
    parameter int SPAD_ADDR_WIDTH   = 3,
    parameter int FILTER_SIZE_WIDTH = 3,
    parameter int REUSE_WIDTH       = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         run_i,
    input  logic [1:0]                   mode_i,
    input  logic [FILTER_SIZE_WIDTH-1:0] filter_size_i,
    input  logic [REUSE_WIDTH-1:0]       reuse_count_i,
    input  logic                         filter_valid_i,
    input  logic                         stall_i,
    output logic                         ren_spad_o,
    output logic [SPAD_ADDR_WIDTH-1:0]   spad_raddr_o,
    output logic                         elem_last_o,
    output logic                         pass_done_o,
    output logic                         r_next_Filter_o,
    output logic                         busy_o
`ifdef SPAD_RD_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cycles_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FILT,
        S_READ,
        S_RELEASE
    } state_e;

    state_e                       state_q, state_d;
    logic [SPAD_ADDR_WIDTH-1:0]   raddr_q, raddr_d;
    logic [REUSE_WIDTH-1:0]       pass_q, pass_d;
    logic                         guard_q, guard_d;

    logic [SPAD_ADDR_WIDTH-1:0]   len;
    logic [SPAD_ADDR_WIDTH-1:0]   last_addr;
    logic [REUSE_WIDTH-1:0]       last_pass;
    logic                         at_last_addr;
    logic                         at_last_pass;

    // Sweep length wraps to the address width exactly as the loader's write side does.
    assign len = (mode_i == 2'd2) ? SPAD_ADDR_WIDTH'({filter_size_i, 1'b0})
                                  : SPAD_ADDR_WIDTH'(filter_size_i);
    assign last_addr    = len - SPAD_ADDR_WIDTH'(1);
    assign last_pass    = (reuse_count_i == '0) ? '0 : reuse_count_i - REUSE_WIDTH'(1);
    assign at_last_addr = (raddr_q == last_addr);
    assign at_last_pass = (pass_q == last_pass);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            raddr_q <= '0;
            pass_q  <= '0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            pass_q  <= pass_d;
            guard_q <= guard_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        raddr_d         = raddr_q;
        pass_d          = pass_q;
        guard_d         = 1'b0;
        ren_spad_o      = 1'b0;
        elem_last_o     = 1'b0;
        pass_done_o     = 1'b0;
        r_next_Filter_o = 1'b0;
        busy_o          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                raddr_d = '0;
                pass_d  = '0;
                if (run_i) state_d = S_WAIT_FILT;
            end
            S_WAIT_FILT: begin
                raddr_d = '0;
                pass_d  = '0;
                // guard_q masks the loader's valid, which is still high for one cycle after release
                if (filter_valid_i && !guard_q) begin
                    state_d = (len != '0) ? S_READ : S_RELEASE;
                end else if (!run_i) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (!stall_i) begin
                    ren_spad_o = 1'b1;
                    if (at_last_addr) begin
                        elem_last_o = 1'b1;
                        pass_done_o = 1'b1;
                        raddr_d     = '0;
                        pass_d      = pass_q + REUSE_WIDTH'(1);
                        if (at_last_pass) state_d = S_RELEASE;
                    end else begin
                        raddr_d = raddr_q + SPAD_ADDR_WIDTH'(1);
                    end
                end
            end
            S_RELEASE: begin
                r_next_Filter_o = 1'b1;
                guard_d         = 1'b1;
                state_d         = run_i ? S_WAIT_FILT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign spad_raddr_o = raddr_q;

`ifdef SPAD_RD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Accumulates across filters; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (state_q == S_READ && stall_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`endif

endmodule
